// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator car controller: latches floor calls, sweeps one direction while calls remain ahead.
// Optional emergency stop input is compiled in with `define ELEVATOR_ESTOP_EN.
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  door_open,
  output logic                  up,
  output logic                  down,
  output logic                  idle,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_err
);

  localparam int TMAX    = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0]    TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    TIMER_ONE   = TIMER_W'(1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]    FLOOR_ONE   = FLOOR_W'(1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = NUM_FLOORS'(1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t                  state_reg, state_next;
  logic [TIMER_W-1:0]      timer_reg, timer_next;
  logic                    dir_up_reg, dir_up_next;
  logic [FLOOR_W-1:0]      floor_next, floor_up, floor_down;
  logic [NUM_FLOORS-1:0]   pending_next, req_mask, here_mask, up_mask, down_mask;
  logic [NUM_FLOORS-1:0]   above_bits, below_bits;
  logic                    req_ok, here_req, above, below, ahead, behind;
  logic                    hit_up, hit_down, err_next, run;

`ifdef ELEVATOR_ESTOP_EN
  assign run = !estop;
`else
  assign run = 1'b1;
`endif

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_side
    assign above_bits[gi] = pending[gi] && (FLOOR_W'(gi) > current_floor);
    assign below_bits[gi] = pending[gi] && (FLOOR_W'(gi) < current_floor);
  end

  assign above      = |above_bits;
  assign below      = |below_bits;
  assign ahead      = dir_up_reg ? above : below;
  assign behind     = dir_up_reg ? below : above;

  assign req_ok     = req_valid && ({1'b0, req_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
  assign err_next   = req_valid && !req_ok;
  assign req_mask   = req_ok ? (ONE_HOT0 << req_floor) : '0;
  assign here_req   = req_ok && (req_floor == current_floor) &&
                      (state_reg == IDLE || state_reg == DOOR_OPEN);

  assign floor_up   = current_floor + FLOOR_ONE;
  assign floor_down = current_floor - FLOOR_ONE;
  assign here_mask  = ONE_HOT0 << current_floor;
  assign up_mask    = ONE_HOT0 << floor_up;
  assign down_mask  = ONE_HOT0 << floor_down;
  // A call landing on the arrival edge counts as a hit so it is served, not dropped
  assign hit_up     = |((pending | req_mask) & up_mask);
  assign hit_down   = |((pending | req_mask) & down_mask);

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    dir_up_next  = dir_up_reg;
    floor_next   = current_floor;
    pending_next = here_req ? pending : (pending | req_mask);
    if (run) begin
      case (state_reg)
        IDLE: begin
          if (here_req) begin
            state_next = DOOR_OPEN;
            timer_next = '0;
          end else if (|(pending & here_mask)) begin
            // Only reachable after an end-floor fallback; serve it instead of moving
            pending_next = pending_next & ~here_mask;
            state_next   = DOOR_OPEN;
            timer_next   = '0;
          end else if (|pending) begin
            timer_next = '0;
            state_next = (above && (dir_up_reg || !below)) ? MOVE_UP : MOVE_DOWN;
          end
        end
        MOVE_UP: begin
          if (timer_reg != TRAVEL_LAST) begin
            timer_next = timer_reg + TIMER_ONE;
          end else begin
            timer_next = '0;
            if (current_floor == TOP_FLOOR) begin
              state_next = IDLE;
            end else begin
              floor_next  = floor_up;
              dir_up_next = 1'b1;
              if (hit_up) begin
                pending_next = pending_next & ~up_mask;
                state_next   = DOOR_OPEN;
              end else if (floor_up == TOP_FLOOR) begin
                state_next = IDLE;
              end
            end
          end
        end
        MOVE_DOWN: begin
          if (timer_reg != TRAVEL_LAST) begin
            timer_next = timer_reg + TIMER_ONE;
          end else begin
            timer_next = '0;
            if (current_floor == '0) begin
              state_next = IDLE;
            end else begin
              floor_next  = floor_down;
              dir_up_next = 1'b0;
              if (hit_down) begin
                pending_next = pending_next & ~down_mask;
                state_next   = DOOR_OPEN;
              end else if (floor_down == '0) begin
                state_next = IDLE;
              end
            end
          end
        end
        DOOR_OPEN: begin
          if (here_req) begin
            timer_next = '0;
          end else if (timer_reg != DOOR_LAST) begin
            timer_next = timer_reg + TIMER_ONE;
          end else begin
            timer_next = '0;
            if (ahead) begin
              state_next = dir_up_reg ? MOVE_UP : MOVE_DOWN;
            end else if (behind) begin
              state_next  = dir_up_reg ? MOVE_DOWN : MOVE_UP;
              dir_up_next = !dir_up_reg;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      dir_up_reg    <= 1'b1;
      current_floor <= '0;
      pending       <= '0;
      door_open     <= 1'b1;
      up            <= 1'b0;
      down          <= 1'b0;
      idle          <= 1'b1;
      req_err       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      dir_up_reg    <= dir_up_next;
      current_floor <= floor_next;
      pending       <= pending_next;
      door_open     <= (state_next == IDLE) || (state_next == DOOR_OPEN);
      up            <= run && (state_next == MOVE_UP);
      down          <= run && (state_next == MOVE_DOWN);
      idle          <= (state_next == IDLE);
      req_err       <= err_next;
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: stimulus queues expected arrivals, idle entries and
// request errors; a negedge monitor pops and compares each observed event.
module tb_elevator_scan_ctrl;
  localparam int NF = 8;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic [FW-1:0] current_floor;
  logic          door_open, up, down, idle, req_err;
  logic [NF-1:0] pending;

  // Second unit with a non-power-of-two floor count so an out-of-range call is expressible
  logic          b_req_valid = 1'b0;
  logic [2:0]    b_req_floor = '0;
  logic [2:0]    b_current_floor;
  logic          b_door_open, b_up, b_down, b_idle, b_req_err;
  logic [5:0]    b_pending;

`ifdef ELEVATOR_ESTOP_EN
  logic estop = 1'b0;
`endif

  elevator_scan_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .req_valid(req_valid), .req_floor(req_floor), .current_floor(current_floor),
    .door_open(door_open), .up(up), .down(down), .idle(idle), .pending(pending), .req_err(req_err)
  );

  elevator_scan_ctrl #(.NUM_FLOORS(6), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut_b (
    .clk(clk), .reset(reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .req_valid(b_req_valid), .req_floor(b_req_floor), .current_floor(b_current_floor),
    .door_open(b_door_open), .up(b_up), .down(b_down), .idle(b_idle), .pending(b_pending),
    .req_err(b_req_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  typedef enum int {EV_ARRIVE = 0, EV_IDLE = 1, EV_ERR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    int            at;
    logic [FW-1:0] floor;
    logic [NF-1:0] pend;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  down_cnt = 0;
  logic prev_door = 1'b0;
  logic prev_idle = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  function automatic void expect_ev(ev_kind_t k, int at, int f, int p);
    ev_t e;
    e.kind  = k;
    e.at    = at;
    e.floor = f[FW-1:0];
    e.pend  = p[NF-1:0];
    exp_q.push_back(e);
  endfunction

  function automatic void observe(ev_kind_t k, logic [FW-1:0] f, logic [NF-1:0] p);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d floor %0d at cycle %0d, required none", k, f, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_cycle", cyc, e.at);
      if (e.kind != EV_ERR) check("event_floor", 32'(f), 32'(e.floor));
      check("event_pending", 32'(p), 32'(e.pend));
      $display("event kind=%0d floor=%0d pending=0x%0h cycle=%0d", k, f, p, cyc);
    end
  endfunction

  // Monitor: door rising = arrival, idle rising = sweep finished, req_err = rejected call
  always @(negedge clk) begin
    if (cyc > 0 && rst_at_edge === 1'b0) begin
      if (b_req_err === 1'b1) observe(EV_ERR, '0, {2'b00, b_pending});
      if (door_open === 1'b1 && prev_door === 1'b0) observe(EV_ARRIVE, current_floor, pending);
      if (idle === 1'b1 && prev_idle === 1'b0) observe(EV_IDLE, current_floor, pending);
    end
    if (down === 1'b1) down_cnt <= down_cnt + 1;
    prev_door <= door_open;
    prev_idle <= idle;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic call(input int f, output int t);
    t = cyc + 1;
    req_valid = 1'b1;
    req_floor = f[FW-1:0];
    tick(1);
    req_valid = 1'b0;
    $display("call floor=%0d edge=%0d", f, t);
  endtask

  initial begin
    int t, t2, d0;

    // Reset held three cycles
    tick(3);
    check("reset_floor", 32'(current_floor), 0);
    check("reset_door", 32'(door_open), 1);
    check("reset_idle", 32'(idle), 1);
    check("reset_pending", 32'(pending), 0);
    check("reset_updown", 32'({up, down}), 0);
    check("reset_err", 32'(req_err), 0);
    reset = 1'b0;
    tick(1);

    // Floor 0 -> 3: floors at +5,+9,+13, door at +13, idle at +21
    call(3, t);
    expect_ev(EV_ARRIVE, t + 1 + 3 * TC, 3, 0);
    expect_ev(EV_IDLE, t + 1 + 3 * TC + DC, 3, 0);
    tick(1);
    check("up_after_start", 32'(up), 1);
    check("floor_before_first_step", 32'(current_floor), 0);
    tick(TC);
    check("floor1_at_edge5", 32'(current_floor), 1);
    tick(20);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);

    // Calls 5 then 2 from floor 0: stop at 2, then 5, never moving down
    d0 = down_cnt;
    call(5, t);
    call(2, t2);
    expect_ev(EV_ARRIVE, t + 1 + 2 * TC, 2, 32'h20);
    expect_ev(EV_ARRIVE, t + 1 + 2 * TC + DC + 3 * TC, 5, 0);
    expect_ev(EV_IDLE, t + 1 + 2 * TC + 2 * DC + 3 * TC, 5, 0);
    tick(40);
    check("no_down_on_upsweep", down_cnt - d0, 0);

    // Reset mid MOVE_DOWN with calls at 3 and 1 pending
    call(3, t);
    call(1, t2);
    check("down_before_reset", 32'(down), 1);
    check("pending_before_reset", 32'(pending), 32'h0A);
    check("floor_before_reset", 32'(current_floor), 5);
    reset = 1'b1;
    tick(1);
    check("midtravel_reset_floor", 32'(current_floor), 0);
    check("midtravel_reset_pending", 32'(pending), 0);
    check("midtravel_reset_outs", 32'({door_open, up, down, idle}), 32'b1001);
    reset = 1'b0;
    tick(1);

    // Go to floor 4, then up to 7 with a call for 1 arriving mid-travel
    call(4, t);
    expect_ev(EV_ARRIVE, t + 1 + 4 * TC, 4, 0);
    expect_ev(EV_IDLE, t + 1 + 4 * TC + DC, 4, 0);
    tick(26);
    call(7, t);
    tick(2);
    call(1, t2);
    d0 = down_cnt;
    expect_ev(EV_ARRIVE, t + 1 + 3 * TC, 7, 32'h02);
    expect_ev(EV_ARRIVE, t + 1 + 3 * TC + DC + 6 * TC, 1, 0);
    expect_ev(EV_IDLE, t + 1 + 3 * TC + 2 * DC + 6 * TC, 1, 0);
    tick(55);
    check("down_cycles_on_reverse", down_cnt - d0, 6 * TC);

    // Call for the floor the idle car is at: door dwell restarts, no pending bit
    call(1, t);
    expect_ev(EV_IDLE, t + DC, 1, 0);
    check("samefloor_idle", 32'(idle), 0);
    check("samefloor_door", 32'(door_open), 1);
    check("samefloor_pending", 32'(pending), 0);
    tick(10);

    // Out-of-range call on the 6-floor unit
    t = cyc + 1;
    expect_ev(EV_ERR, t, 0, 0);
    b_req_valid = 1'b1;
    b_req_floor = 3'd7;
    tick(1);
    b_req_valid = 1'b0;
    $display("call floor=7 on 6-floor unit edge=%0d", t);
    tick(1);
    check("req_err_one_cycle", 32'(b_req_err), 0);
    check("req_err_pending", 32'(b_pending), 0);
    tick(3);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
